prime_pair_ctrl: RTL and testbench

//  Sequencer that turns a random-word stream and one shared Miller-Rabin tester into a key pair.
//  It builds odd candidates, launches the tester with a start/done handshake and keeps the first prime as P.
//  It keeps the next distinct prime as Q, then presents {P,Q} to the key-pair consumer.

---
 rtl/prime_pair_ctrl.sv | 134 +++++++++++++
 tb/tb_prime_pair_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_pair_ctrl.sv
// Sequencer pairing a random-word source with one shared Miller-Rabin tester to produce two distinct primes P and Q.
// The first mr_start comes 2 cycles after gen_req; each candidate then costs 3 cycles plus tester time.
module prime_pair_ctrl #(
    parameter int unsigned RAND_W    = 16,
    parameter int unsigned WORDSIZE  = 32,
    parameter int unsigned ACCURACY  = 8,
    parameter int unsigned MAX_TRIES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_gen_req,
    input  logic [RAND_W-1:0]   i_rand_a,
    input  logic [RAND_W-1:0]   i_rand_b,
    input  logic                i_rand_valid,
    output logic                o_mr_start,
    output logic [WORDSIZE-1:0] o_mr_candidate,
    output logic [WORDSIZE-1:0] o_mr_accuracy,
    input  logic                i_mr_done,
    input  logic                i_mr_prime,
    output logic [WORDSIZE-1:0] o_key_p,
    output logic [WORDSIZE-1:0] o_key_q,
    output logic                o_keys_valid,
    output logic                o_busy,
    output logic                o_fail,
    output logic [15:0]         o_tries
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_EVAL, S_DONE, S_FAIL
    } state_t;

    state_t              r_state;
    logic                r_have_p;
    logic                r_prime;
    logic                r_mr_start;
    logic [WORDSIZE-1:0] r_cand;
    logic [WORDSIZE-1:0] r_key_p;
    logic [WORDSIZE-1:0] r_key_q;
    logic                r_keys_valid;
    logic                r_busy;
    logic                r_fail;
    logic [15:0]         r_tries;

    logic [WORDSIZE-1:0] w_cand;
    logic                w_last_try;
    logic                w_unused;

    // Top bit and bottom bit are forced, so rand_a's MSB and rand_b's LSB never reach the candidate.
    assign w_cand     = {1'b1, i_rand_a[RAND_W-2:0], i_rand_b[RAND_W-1:1], 1'b1};
    assign w_unused   = ^{i_rand_a[RAND_W-1], i_rand_b[0]};
    assign w_last_try = (32'(r_tries) == MAX_TRIES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_have_p     <= 1'b0;
            r_prime      <= 1'b0;
            r_mr_start   <= 1'b0;
            r_cand       <= '0;
            r_key_p      <= '0;
            r_key_q      <= '0;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
            r_tries      <= '0;
        end else begin
            r_mr_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (i_gen_req) begin
                        r_state      <= S_FETCH;
                        r_keys_valid <= 1'b0;
                        r_fail       <= 1'b0;
                        r_tries      <= '0;
                        r_have_p     <= 1'b0;
                        r_key_p      <= '0;
                        r_key_q      <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (i_rand_valid) begin
                        r_cand     <= w_cand;
                        r_mr_start <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (r_tries != 16'hFFFF) r_tries <= r_tries + 16'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mr_done) begin
                        r_prime <= i_mr_prime;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_prime && r_have_p && (r_cand != r_key_p)) begin
                        r_key_q      <= r_cand;
                        r_keys_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        // A repeat of P falls through here and is handled like a composite.
                        if (r_prime && !r_have_p) begin
                            r_key_p  <= r_cand;
                            r_have_p <= 1'b1;
                        end
                        if (w_last_try) begin
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FAIL;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mr_start     = r_mr_start;
    assign o_mr_candidate = r_cand;
    assign o_mr_accuracy  = WORDSIZE'(ACCURACY);
    assign o_key_p        = r_key_p;
    assign o_key_q        = r_key_q;
    assign o_keys_valid   = r_keys_valid;
    assign o_busy         = r_busy;
    assign o_fail         = r_fail;
    assign o_tries        = r_tries;

endmodule

// File: tb/tb_prime_pair_ctrl.sv
// Bench for prime_pair_ctrl: candidate-forming table, hand sequences for corner cases, randomized requests vs a pair-search model.
module tb_prime_pair_ctrl;
    localparam int MAX_T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_gen_req = 1'b0;
    logic [15:0] i_rand_a = '0;
    logic [15:0] i_rand_b = '0;
    logic        i_rand_valid = 1'b0;
    logic        i_mr_done = 1'b0;
    logic        i_mr_prime = 1'b0;
    logic        o_mr_start, o_keys_valid, o_busy, o_fail;
    logic [31:0] o_mr_candidate, o_mr_accuracy, o_key_p, o_key_q;
    logic [15:0] o_tries;

    prime_pair_ctrl #(.RAND_W(16), .WORDSIZE(32), .ACCURACY(8), .MAX_TRIES(MAX_T)) dut (
        .clk(clk), .reset(reset), .i_gen_req(i_gen_req),
        .i_rand_a(i_rand_a), .i_rand_b(i_rand_b), .i_rand_valid(i_rand_valid),
        .o_mr_start(o_mr_start), .o_mr_candidate(o_mr_candidate), .o_mr_accuracy(o_mr_accuracy),
        .i_mr_done(i_mr_done), .i_mr_prime(i_mr_prime),
        .o_key_p(o_key_p), .o_key_q(o_key_q), .o_keys_valid(o_keys_valid),
        .o_busy(o_busy), .o_fail(o_fail), .o_tries(o_tries)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Per-request stimulus: rand words and tester verdict for the k-th launched candidate.
    logic [15:0] wa[MAX_T];
    logic [15:0] wb[MAX_T];
    bit          vd[MAX_T];
    int          lat_max = 1;
    bit          spur = 0;
    bit          greq_noise = 0;
    bit          vgap = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] cand;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] form(input logic [15:0] a, input logic [15:0] b);
        return 32'h8000_0001 | ({16'h0, a & 16'h7fff} << 16) | {16'h0, b & 16'hfffe};
    endfunction

    task automatic do_reset();
        reset = 1'b1; i_gen_req = 0; i_rand_valid = 0; i_mr_done = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    // Plays the tester and random source for one request, then scores the outcome against the model.
    task automatic do_request(input string tag);
        int starts = 0, cyc = 0, cnt = 0, unstable = 0, badc = 0;
        bit pend = 0, fin = 0;
        logic [31:0] cur = '0;
        logic [31:0] got[$];
        bit ev = 0, hp = 0;
        logic [31:0] ep = '0, eq = '0, c;
        int et = 0;

        for (int k = 0; k < MAX_T && !ev; k++) begin
            c = form(wa[k], wb[k]);
            et++;
            if (vd[k]) begin
                if (!hp) begin hp = 1; ep = c; end
                else if (c != ep) begin eq = c; ev = 1; end
            end
        end

        @(negedge clk);
        i_gen_req = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 400) begin
            i_mr_done = 1'b0;
            i_gen_req = 1'b0;
            if (o_keys_valid || o_fail) begin
                fin = 1;
            end else begin
                if (o_mr_start) begin
                    got.push_back(o_mr_candidate);
                    cur = o_mr_candidate;
                    starts++;
                    pend = 1;
                    cnt = $urandom_range(1, lat_max);
                    if (spur) i_mr_done = 1'($urandom_range(0, 1));
                    i_mr_prime = 1'($urandom);
                end else if (pend) begin
                    if (o_mr_candidate !== cur) unstable++;
                    cnt--;
                    if (cnt == 0) begin
                        i_mr_done = 1'b1;
                        i_mr_prime = (starts <= MAX_T) ? vd[starts-1] : 1'b0;
                        pend = 0;
                    end
                end else if (spur) begin
                    i_mr_done = ($urandom_range(0, 3) == 0);
                    i_mr_prime = 1'($urandom);
                end
                if (greq_noise) i_gen_req = ($urandom_range(0, 3) == 0);
                i_rand_a = (starts < MAX_T) ? wa[starts] : 16'($urandom);
                i_rand_b = (starts < MAX_T) ? wb[starts] : 16'($urandom);
                i_rand_valid = vgap ? ($urandom_range(0, 2) != 0) : 1'b1;
                cyc++;
                @(negedge clk);
            end
        end
        i_mr_done = 1'b0;
        i_gen_req = 1'b0;
        if (!fin) check({tag, ".timeout"}, 32'd0, 32'd1);
        for (int k = 0; k < got.size(); k++)
            if (k >= MAX_T || got[k] !== form(wa[k], wb[k])) badc++;
        check({tag, ".keys_valid"}, {31'b0, o_keys_valid}, {31'b0, ev});
        check({tag, ".fail"}, {31'b0, o_fail}, {31'b0, !ev});
        check({tag, ".key_p"}, o_key_p, ep);
        check({tag, ".key_q"}, o_key_q, eq);
        check({tag, ".tries"}, {16'b0, o_tries}, et);
        check({tag, ".starts"}, starts, et);
        check({tag, ".busy"}, {31'b0, o_busy}, 32'd0);
        check({tag, ".cand_stable"}, unstable, 32'd0);
        check({tag, ".cand_values"}, badc, 32'd0);
    endtask

    initial begin
        int viol;
        int pool_a[3], pool_b[3];

        tbl[0] = '{16'h0000, 16'h0000, 32'h8000_0001};
        tbl[1] = '{16'hffff, 16'hffff, 32'hffff_ffff};
        tbl[2] = '{16'h8001, 16'h0003, 32'h8001_0003};
        tbl[3] = '{16'h7fff, 16'h0000, 32'hffff_0001};
        tbl[4] = '{16'h0000, 16'hfffe, 32'h8000_ffff};
        tbl[5] = '{16'h8005, 16'h0006, 32'h8005_0007};
        tbl[6] = '{16'h1234, 16'h5678, 32'h9234_5679};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst.mr_start", {31'b0, o_mr_start}, 0);
        check("rst.cand", o_mr_candidate, 0);
        check("rst.accuracy", o_mr_accuracy, 32'd8);
        check("rst.key_p", o_key_p, 0);
        check("rst.key_q", o_key_q, 0);
        check("rst.flags", {29'b0, o_keys_valid, o_busy, o_fail}, 0);
        check("rst.tries", {16'b0, o_tries}, 0);

        // Candidate forming and gen_req-to-launch latency
        for (int i = 0; i < 7; i++) begin
            do_reset();
            i_gen_req = 1; i_rand_valid = 1; i_rand_a = tbl[i].a; i_rand_b = tbl[i].b;
            @(negedge clk);
            i_gen_req = 0;
            check($sformatf("tbl%0d.no_start_fetch", i), {31'b0, o_mr_start}, 0);
            @(negedge clk);
            check($sformatf("tbl%0d.start", i), {31'b0, o_mr_start}, 1);
            check($sformatf("tbl%0d.cand", i), o_mr_candidate, tbl[i].cand);
        end

        // Duplicate prime is rejected as Q
        do_reset();
        wa = '{16'h8001, 16'h8001, 16'h8005, 16'h0000};
        wb = '{16'h0003, 16'h0003, 16'h0007, 16'h0000};
        vd = '{1, 1, 1, 0};
        lat_max = 2;
        do_request("dup");
        check("dup.key_p_const", o_key_p, 32'h8001_0003);
        check("dup.key_q_const", o_key_q, 32'h8005_0007);
        check("dup.tries_const", {16'b0, o_tries}, 32'd3);

        // All composite -> give up after MAX_TRIES launches
        for (int k = 0; k < MAX_T; k++) begin wa[k] = 16'($urandom); wb[k] = 16'($urandom); vd[k] = 0; end
        do_request("exhaust");
        check("exhaust.tries_const", {16'b0, o_tries}, MAX_T);

        // rand_valid withheld: stay in FETCH
        do_reset();
        i_gen_req = 1; i_rand_valid = 0;
        @(negedge clk);
        i_gen_req = 0;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_mr_start !== 1'b0 || o_busy !== 1'b1) viol++;
            @(negedge clk);
        end
        check("starve.hold", viol, 0);
        i_rand_valid = 1; i_rand_a = 16'h0042; i_rand_b = 16'h0010;
        check("starve.no_start_yet", {31'b0, o_mr_start}, 0);
        @(negedge clk);
        check("starve.start", {31'b0, o_mr_start}, 1);
        check("starve.cand", o_mr_candidate, 32'h8042_0011);

        // Reset while waiting on the tester
        @(negedge clk);
        check("wait.busy", {31'b0, o_busy}, 1);
        reset = 1;
        @(negedge clk);
        check("wreset.mr_start", {31'b0, o_mr_start}, 0);
        check("wreset.cand", o_mr_candidate, 0);
        check("wreset.accuracy", o_mr_accuracy, 32'd8);
        check("wreset.keys", o_key_p | o_key_q, 0);
        check("wreset.flags", {29'b0, o_keys_valid, o_busy, o_fail}, 0);
        check("wreset.tries", {16'b0, o_tries}, 0);
        reset = 0; i_rand_valid = 0;
        i_mr_done = 1; i_mr_prime = 1;
        @(negedge clk);
        i_mr_done = 0;
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_mr_start !== 1'b0 || o_busy !== 1'b0 || o_keys_valid !== 1'b0) viol++;
            @(negedge clk);
        end
        check("wreset.late_done_ignored", viol, 0);
        for (int k = 0; k < MAX_T; k++) begin wa[k] = 16'($urandom); wb[k] = 16'($urandom); vd[k] = 1'(k != 0); end
        do_request("after_reset");

        // Spurious mr_done and gen_req while busy
        spur = 1; greq_noise = 1; lat_max = 3;
        for (int k = 0; k < MAX_T; k++) begin wa[k] = 16'($urandom); wb[k] = 16'($urandom); vd[k] = 1'(k >= 1); end
        do_request("noise");

        // Randomized requests, small word pool so duplicates recur
        vgap = 1;
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < 3; j++) begin pool_a[j] = int'($urandom_range(0, 65535)); pool_b[j] = int'($urandom_range(0, 65535)); end
            for (int k = 0; k < MAX_T; k++) begin
                int idx;
                idx = int'($urandom_range(0, 2));
                wa[k] = 16'(pool_a[idx]);
                wb[k] = 16'(pool_b[idx]);
                vd[k] = 1'($urandom_range(0, 1));
            end
            lat_max = int'($urandom_range(1, 4));
            spur = 1'($urandom_range(0, 1));
            greq_noise = 1'($urandom_range(0, 1));
            do_request($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
